urp_pcie_tx_replay_ctrl: RTL and testbench
==========================================

# urp_pcie_tx_replay_ctrl

Replay controller for the PCIe TX data link layer. It owns the transmit sequence counter and the acknowledged-sequence pointer. It decodes incoming Ack/Nak DLLPs, issues purge commands to the retry buffer, and runs the replay timer and REPLAY_NUM counter. On a Nak or a timeout it sequences a replay of every outstanding TLP. It sits beside the retry buffer and gates acceptance of new TLPs from the transaction layer.

## Interface
- DEPTH_LG2, 4: log2 of the retry buffer entry count; outstanding TLPs are limited to 2**DEPTH_LG2.
- REPLAY_TIMEOUT, 1024: replay timer expiry, in clk cycles.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- new_tlp_ready_o  out  1  a new TLP may be sent this cycle.
- tlp_sent_i  in  1  a new TLP was stamped with next_seq_o and written to the retry buffer this cycle.
- next_seq_o  out  12  sequence number for the next new TLP.
- dllp_valid_i  in  1  dllp_i is valid this cycle.
- dllp_i  in  32  [31:24] type (8'h00 Ack, 8'h10 Nak, others ignored); [11:0] AckNak_Seq.
- purge_valid_o  out  1  one-cycle pulse: the retry buffer deletes all entries up to and including purge_seq_o.
- purge_seq_o  out  12  last acknowledged sequence number.
- replay_valid_o  out  1  request to retransmit the retry buffer entry replay_seq_o.
- replay_seq_o  out  12  sequence number being replayed.
- replay_ready_i  in  1  replay beat accepted.
- replay_num_o  out  2  current REPLAY_NUM.
- link_retrain_o  out  1  one-cycle pulse: REPLAY_NUM rolled over.
- dllp_err_o  out  1  one-cycle pulse: Ack/Nak carried an out-of-range sequence number.

## Operation
- Registers: next_seq (reset 12'd0), ackd_seq (reset 12'hFFF), replay cursor, timer, replay_num (reset 0).
- All sequence arithmetic is mod 4096.
- outstanding = next_seq - ackd_seq - 1 (12-bit).
- full = (outstanding == 2**DEPTH_LG2).
- tlp_sent_i is honoured only while new_tlp_ready_o = 1; when honoured, next_seq increments. Otherwise it is ignored.
- Ack/Nak decode: d = AckNak_Seq - ackd_seq.
  - d > outstanding: pulse dllp_err_o and ignore the DLLP entirely.
  - d > 0: set ackd_seq = AckNak_Seq, pulse purge, zero replay_num, and restart the timer.
  - d == 0: no purge.
- Nak in IDLE: apply the Ack rule above. Then, if outstanding after the purge is greater than 0, start a replay.
- Timer:
  - Counts only in IDLE while outstanding > 0.
  - Holds at 0 when outstanding == 0.
  - Clears to 0 on an Ack with progress and on replay end.
  - On reaching REPLAY_TIMEOUT-1, it starts a replay.
- Replay start:
  - Set cursor = ackd_seq + 1.
  - If replay_num == 3: pulse link_retrain_o and wrap replay_num to 0. Otherwise increment replay_num.
  - The replay proceeds in both cases.
- FSM has two states:
  - IDLE: new_tlp_ready_o = !full.
  - REPLAY: new_tlp_ready_o = 0; replay_valid_o = 1; replay_seq_o = cursor.
  - On replay_ready_i, cursor increments.
  - When the beat with cursor == next_seq-1 is accepted, return to IDLE with the timer at 0.
- Ack during REPLAY: the purge applies. If the new ackd_seq is at or beyond the cursor, the cursor jumps to ackd_seq+1. If outstanding becomes 0, return to IDLE immediately and deassert replay_valid_o.
- Nak during REPLAY: only the purge part applies. It causes no restart and no replay_num change.
- tlp_sent_i and an Ack in the same cycle: both take effect; outstanding uses the updated values.
- Asynchronous reset mid-replay: the FSM returns to IDLE and all registers take their reset values.

## Timing
- Reset values:
  - new_tlp_ready_o = 1; next_seq_o = 0; purge_seq_o = 12'hFFF.
  - replay_valid_o, replay_seq_o, replay_num_o, link_retrain_o, purge_valid_o, dllp_err_o all = 0.
- All outputs are registered.
- The DLLP is sampled at edge N. At edge N+1:
  - purge_valid_o, dllp_err_o and link_retrain_o pulse.
  - replay_valid_o asserts when a Nak starts a replay.
- Timer expiry: replay_valid_o asserts one cycle after the timer reaches REPLAY_TIMEOUT-1.
- Replay handshake is valid/ready. replay_seq_o is stable while replay_valid_o=1 and replay_ready_i=0. Sustained throughput is one beat per cycle.
- next_seq_o updates the cycle after an honoured tlp_sent_i.
- new_tlp_ready_o reflects full and the state as of the previous edge.

## Structure
- Package urp_pcie_dll_pkg contains:
  - SEQ_W = 12, typedef seq_t.
  - DLLP_TYPE_ACK = 8'h00, DLLP_TYPE_NAK = 8'h10.
  - Function seq_diff(a, b) returning the 12-bit modular difference.
  - The replay FSM state enum.
- Sub-module urp_pcie_replay_timer contains the counter with clear, enable and expire pulse, parameterised by REPLAY_TIMEOUT.

## Test plan
- Send 3 TLPs, then Ack seq 1 -> purge_seq_o = 1 one cycle later; next_seq_o = 3; outstanding = 1; replay_num_o = 0.
- Send 16 TLPs -> new_tlp_ready_o = 0. Then Ack seq 0 -> new_tlp_ready_o returns to 1.
- Send 5 TLPs, then Nak seq 1 -> purge 1; replay beats 2, 3, 4 with replay_ready_i toggling; return to IDLE; replay_num_o = 1.
- No Ack for 1024 cycles with 2 outstanding -> replay of 0 and 1. Repeat the timeout 4 times -> link_retrain_o pulses on the 4th; replay_num_o = 0.
- Ack seq 100 with 3 outstanding -> dllp_err_o pulses; no purge; state unchanged.
- Start next_seq at 4094, send 4 TLPs, then Ack seq 0 -> purge_seq_o = 0; outstanding = 1 (wrap).

Source files
------------

// File: rtl/urp_pcie_dll_pkg.sv
// Shared definitions for the PCIe TX data link layer replay logic.
// Contents: sequence number type and width, Ack/Nak DLLP type codes,
// modular sequence difference helper, replay FSM state encoding.
package urp_pcie_dll_pkg;

    localparam int unsigned SEQ_W = 12;

    typedef logic [SEQ_W-1:0] seq_t;

    localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
    localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

    // Distance from b forward to a, modulo 2**SEQ_W.
    function automatic seq_t seq_diff(input seq_t a, input seq_t b);
        return a - b;
    endfunction

    typedef enum logic {
        ST_IDLE,
        ST_REPLAY
    } replay_state_t;

endpackage

// File: rtl/urp_pcie_tx_replay_ctrl_if.sv
// Handshake bundle between the replay controller and its neighbours
// (transaction layer, DLLP receiver, retry buffer).
// slave  : the replay controller side.
// master : the environment side (TLP source, DLLP decoder, retry buffer).
// Signals:
//   new_tlp_ready_o / tlp_sent_i / next_seq_o  - new TLP admission and stamping
//   dllp_valid_i / dllp_i                      - received Ack/Nak DLLPs
//   purge_valid_o / purge_seq_o                - retry buffer purge command
//   replay_valid_o / replay_seq_o / replay_ready_i - replay beat handshake
//   replay_num_o / link_retrain_o / dllp_err_o - status
interface urp_pcie_tx_replay_ctrl_if;
    import urp_pcie_dll_pkg::*;

    logic        new_tlp_ready_o;
    logic        tlp_sent_i;
    seq_t        next_seq_o;
    logic        dllp_valid_i;
    logic [31:0] dllp_i;
    logic        purge_valid_o;
    seq_t        purge_seq_o;
    logic        replay_valid_o;
    seq_t        replay_seq_o;
    logic        replay_ready_i;
    logic [1:0]  replay_num_o;
    logic        link_retrain_o;
    logic        dllp_err_o;

    modport slave (
        output new_tlp_ready_o, next_seq_o, purge_valid_o, purge_seq_o,
               replay_valid_o, replay_seq_o, replay_num_o, link_retrain_o,
               dllp_err_o,
        input  tlp_sent_i, dllp_valid_i, dllp_i, replay_ready_i
    );

    modport master (
        input  new_tlp_ready_o, next_seq_o, purge_valid_o, purge_seq_o,
               replay_valid_o, replay_seq_o, replay_num_o, link_retrain_o,
               dllp_err_o,
        output tlp_sent_i, dllp_valid_i, dllp_i, replay_ready_i
    );

endinterface

// File: rtl/urp_pcie_replay_timer.sv
// Replay timer: counts enabled cycles and flags expiry.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - force count to zero (wins over en)
//   en         - count this cycle
//   expire     - count is at REPLAY_TIMEOUT-1 while enabled; count wraps to 0
module urp_pcie_replay_timer #(
    parameter int unsigned REPLAY_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = (REPLAY_TIMEOUT > 2) ? $clog2(REPLAY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(REPLAY_TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    assign expire = en && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= expire ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/urp_pcie_tx_replay_ctrl.sv
// Replay controller for the PCIe TX data link layer.
// Owns the transmit sequence counter and the acknowledged-sequence pointer,
// decodes Ack/Nak DLLPs, commands retry buffer purges, runs the replay timer
// and REPLAY_NUM, and sequences replays of outstanding TLPs.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - handshake bundle (slave side), see urp_pcie_tx_replay_ctrl_if
module urp_pcie_tx_replay_ctrl
    import urp_pcie_dll_pkg::*;
#(
    parameter int unsigned DEPTH_LG2      = 4,
    parameter int unsigned REPLAY_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    urp_pcie_tx_replay_ctrl_if.slave bus
);

    localparam seq_t MAX_OUT = seq_t'(1 << DEPTH_LG2);

    replay_state_t state, state_n;
    seq_t          next_seq, next_seq_n;
    seq_t          ackd_seq, ackd_n;
    seq_t          cursor, cursor_n;
    logic [1:0]    replay_num, replay_num_n;
    logic          purge_valid, purge_n;
    logic          dllp_err, err_n;
    logic          link_retrain, retrain_n;

    seq_t outstanding, out_n, d, dllp_seq, cur1;
    logic full, tlp_ready, sent, is_ack, is_nak, acknak, err, progress;
    logic beat, last_beat, start;
    logic timer_clr, timer_en, timer_expire;

    assign outstanding = seq_diff(next_seq, ackd_seq) - seq_t'(1);
    assign full        = (outstanding == MAX_OUT);
    assign tlp_ready   = (state == ST_IDLE) && !full;
    assign sent        = bus.tlp_sent_i && tlp_ready;
    assign next_seq_n  = sent ? next_seq + seq_t'(1) : next_seq;

    assign dllp_seq = bus.dllp_i[SEQ_W-1:0];
    assign is_ack   = bus.dllp_valid_i && (bus.dllp_i[31:24] == DLLP_TYPE_ACK);
    assign is_nak   = bus.dllp_valid_i && (bus.dllp_i[31:24] == DLLP_TYPE_NAK);
    assign acknak   = is_ack || is_nak;
    assign d        = seq_diff(dllp_seq, ackd_seq);
    // Range check uses pre-send outstanding: a TLP stamped this cycle cannot be acked yet.
    assign err      = acknak && (d > outstanding);
    assign progress = acknak && !err && (d != '0);
    assign ackd_n   = progress ? dllp_seq : ackd_seq;
    assign out_n    = seq_diff(next_seq_n, ackd_n) - seq_t'(1);

    assign beat      = (state == ST_REPLAY) && bus.replay_ready_i;
    assign last_beat = beat && (cursor == next_seq - seq_t'(1));
    assign cur1      = beat ? cursor + seq_t'(1) : cursor;

    assign timer_en = (state == ST_IDLE) && (outstanding != '0);

    urp_pcie_replay_timer #(
        .REPLAY_TIMEOUT(REPLAY_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (timer_expire)
    );

    always_comb begin
        state_n      = state;
        cursor_n     = cursor;
        replay_num_n = replay_num;
        purge_n      = progress;
        err_n        = err;
        retrain_n    = 1'b0;
        start        = 1'b0;
        timer_clr    = progress || (outstanding == '0);

        // A Nak arriving mid-replay only purges; REPLAY_NUM is left alone.
        if (progress && !(state == ST_REPLAY && is_nak)) begin
            replay_num_n = '0;
        end

        unique case (state)
            ST_IDLE: begin
                // An Ack that makes progress restarts the timer, so it suppresses
                // a coincident expiry.
                start = (is_nak && !err && (out_n != '0)) || (timer_expire && !progress);
                if (start) begin
                    cursor_n = ackd_n + seq_t'(1);
                    state_n  = ST_REPLAY;
                    if (replay_num_n == 2'd3) begin
                        replay_num_n = '0;
                        retrain_n    = 1'b1;
                    end else begin
                        replay_num_n = replay_num_n + 2'd1;
                    end
                end
            end
            ST_REPLAY: begin
                cursor_n = cur1;
                if ((out_n == '0) || last_beat) begin
                    state_n   = ST_IDLE;
                    timer_clr = 1'b1;
                end else if (progress &&
                             seq_diff(ackd_n, ackd_seq) >= seq_diff(cur1, ackd_seq)) begin
                    // Purge overtook the cursor: skip entries the buffer no longer holds.
                    cursor_n = ackd_n + seq_t'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            next_seq     <= '0;
            ackd_seq     <= '1;
            cursor       <= '0;
            replay_num   <= '0;
            purge_valid  <= 1'b0;
            dllp_err     <= 1'b0;
            link_retrain <= 1'b0;
        end else begin
            state        <= state_n;
            next_seq     <= next_seq_n;
            ackd_seq     <= ackd_n;
            cursor       <= cursor_n;
            replay_num   <= replay_num_n;
            purge_valid  <= purge_n;
            dllp_err     <= err_n;
            link_retrain <= retrain_n;
        end
    end

    assign bus.new_tlp_ready_o = tlp_ready;
    assign bus.next_seq_o      = next_seq;
    assign bus.purge_valid_o   = purge_valid;
    assign bus.purge_seq_o     = ackd_seq;
    assign bus.replay_valid_o  = (state == ST_REPLAY);
    assign bus.replay_seq_o    = cursor;
    assign bus.replay_num_o    = replay_num;
    assign bus.link_retrain_o  = link_retrain;
    assign bus.dllp_err_o      = dllp_err;

endmodule

// File: tb/tb_urp_pcie_tx_replay_ctrl.sv
// Self-checking bench for urp_pcie_tx_replay_ctrl (DEPTH_LG2=4, REPLAY_TIMEOUT=1024).
module tb_urp_pcie_tx_replay_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    urp_pcie_tx_replay_ctrl_if bus();

    urp_pcie_tx_replay_ctrl #(
        .DEPTH_LG2      (4),
        .REPLAY_TIMEOUT (1024)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.tlp_sent_i     = 1'b0;
        bus.dllp_valid_i   = 1'b0;
        bus.dllp_i         = '0;
        bus.replay_ready_i = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_tlps(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tlp_sent_i = 1'b1;
            tick();
        end
        bus.tlp_sent_i = 1'b0;
    endtask

    task automatic send_dllp(input logic [7:0] typ, input logic [11:0] seq);
        bus.dllp_valid_i = 1'b1;
        bus.dllp_i       = {typ, 12'h000, seq};
        tick();
        bus.dllp_valid_i = 1'b0;
        bus.dllp_i       = '0;
    endtask

    // Ticks until replay_valid_o rises; returns -1 when the bound runs out.
    task automatic wait_replay(input int bound, output int cycles);
        cycles = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (bus.replay_valid_o) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int seen[$];
        int mn, ma, out, dm, seq, r, guard;
        logic tlp, dv, err_e, prog_e, ready_e;
        logic [7:0] typ;

        // ---------------- reset state
        apply_reset();
        chk("rst_ready", bus.new_tlp_ready_o, 1);
        chk("rst_next_seq", bus.next_seq_o, 0);
        chk("rst_purge_seq", bus.purge_seq_o, 12'hFFF);
        chk("rst_purge_valid", bus.purge_valid_o, 0);
        chk("rst_replay_valid", bus.replay_valid_o, 0);
        chk("rst_replay_seq", bus.replay_seq_o, 0);
        chk("rst_replay_num", bus.replay_num_o, 0);
        chk("rst_retrain", bus.link_retrain_o, 0);
        chk("rst_err", bus.dllp_err_o, 0);

        // ---------------- 3 TLPs then Ack 1
        send_tlps(3);
        chk("t1_next_seq_pre", bus.next_seq_o, 3);
        send_dllp(8'h00, 12'd1);
        chk("t1_purge_valid", bus.purge_valid_o, 1);
        chk("t1_purge_seq", bus.purge_seq_o, 1);
        chk("t1_next_seq", bus.next_seq_o, 3);
        chk("t1_outstanding", 32'((bus.next_seq_o - bus.purge_seq_o - 12'd1) & 12'hFFF), 1);
        chk("t1_replay_num", bus.replay_num_o, 0);
        tick();
        chk("t1_purge_pulse_end", bus.purge_valid_o, 0);

        // ---------------- fill to 16 outstanding
        apply_reset();
        send_tlps(15);
        chk("t2_ready_at15", bus.new_tlp_ready_o, 1);
        send_tlps(1);
        chk("t2_full_ready", bus.new_tlp_ready_o, 0);
        send_tlps(1);
        chk("t2_ignored_send", bus.next_seq_o, 16);
        send_dllp(8'h00, 12'd0);
        chk("t2_ready_back", bus.new_tlp_ready_o, 1);
        chk("t2_purge_seq", bus.purge_seq_o, 0);

        // ---------------- Nak with toggling replay_ready
        apply_reset();
        send_tlps(5);
        send_dllp(8'h10, 12'd1);
        chk("t3_purge_valid", bus.purge_valid_o, 1);
        chk("t3_purge_seq", bus.purge_seq_o, 1);
        chk("t3_replay_valid", bus.replay_valid_o, 1);
        chk("t3_ready_blocked", bus.new_tlp_ready_o, 0);
        chk("t3_replay_num", bus.replay_num_o, 1);
        seen.delete();
        for (int i = 0; i < 40 && bus.replay_valid_o; i++) begin
            bus.replay_ready_i = i[0];
            if (bus.replay_ready_i) seen.push_back(int'(bus.replay_seq_o));
            tick();
        end
        bus.replay_ready_i = 1'b0;
        chk("t3_beat_count", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) chk("t3_beat_seq", seen[i], 2 + i);
        chk("t3_back_idle", bus.replay_valid_o, 0);
        chk("t3_ready_idle", bus.new_tlp_ready_o, 1);
        chk("t3_replay_num_end", bus.replay_num_o, 1);

        // ---------------- timeouts with 2 outstanding
        apply_reset();
        send_tlps(2);
        bus.replay_ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_replay(1200, cyc);
            // First TLP was sent one edge earlier than the wait began.
            chk("t4_timeout_cycles", cyc, (k == 1) ? 1023 : 1024);
            chk("t4_retrain", bus.link_retrain_o, (k == 4) ? 1 : 0);
            chk("t4_replay_num", bus.replay_num_o, k % 4);
            seen.delete();
            for (int i = 0; i < 10 && bus.replay_valid_o; i++) begin
                seen.push_back(int'(bus.replay_seq_o));
                tick();
            end
            chk("t4_beat_count", seen.size(), 2);
            for (int i = 0; i < 2 && i < seen.size(); i++) chk("t4_beat_seq", seen[i], i);
            chk("t4_retrain_pulse", bus.link_retrain_o, 0);
        end
        bus.replay_ready_i = 1'b0;

        // ---------------- out-of-range Ack, then range boundary
        apply_reset();
        send_tlps(3);
        send_dllp(8'h00, 12'd100);
        chk("t5_err", bus.dllp_err_o, 1);
        chk("t5_no_purge", bus.purge_valid_o, 0);
        chk("t5_purge_seq", bus.purge_seq_o, 12'hFFF);
        chk("t5_next_seq", bus.next_seq_o, 3);
        chk("t5_no_replay", bus.replay_valid_o, 0);
        send_dllp(8'h00, 12'd2);
        chk("t5_edge_ok", bus.dllp_err_o, 0);
        chk("t5_edge_purge", bus.purge_seq_o, 2);
        send_dllp(8'h00, 12'd3);
        chk("t5_beyond_err", bus.dllp_err_o, 1);
        chk("t5_beyond_seq", bus.purge_seq_o, 2);

        // ---------------- Ack overtaking replay cursor
        apply_reset();
        send_tlps(5);
        send_dllp(8'h10, 12'd0);
        chk("t6_cursor_start", bus.replay_seq_o, 1);
        send_dllp(8'h00, 12'd2);
        chk("t6_cursor_jump", bus.replay_seq_o, 3);
        chk("t6_still_replay", bus.replay_valid_o, 1);
        send_dllp(8'h00, 12'd4);
        chk("t6_drop_valid", bus.replay_valid_o, 0);
        chk("t6_purge_seq", bus.purge_seq_o, 4);
        chk("t6_ready", bus.new_tlp_ready_o, 1);

        // ---------------- asynchronous reset mid-replay
        send_tlps(2);
        send_dllp(8'h10, 12'd4);
        chk("t7_in_replay", bus.replay_valid_o, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", bus.replay_valid_o, 0);
        chk("t7_rst_next", bus.next_seq_o, 0);
        chk("t7_rst_purge", bus.purge_seq_o, 12'hFFF);
        apply_reset();

        // ---------------- random TLP/Ack traffic against a model, up to seq 4094
        mn = 0;
        ma = 4095;
        guard = 0;
        while (!((mn == 4094) && (((mn - ma - 1) & 12'hFFF) == 0)) && guard < 30000) begin
            guard++;
            out     = (mn - ma - 1) & 12'hFFF;
            ready_e = (out != 16);
            tlp     = (mn != 4094) && ($urandom % 4 != 0);
            dv      = ($urandom % 4 == 0);
            r       = $urandom % 20;
            if (r < 14) begin
                typ = 8'h00;
                seq = (out > 0) ? ((ma + 1 + $urandom % out) & 12'hFFF) : ma;
            end else if (r < 17) begin
                typ = 8'h00;
                seq = (ma + out + 1 + $urandom % 50) & 12'hFFF;
            end else begin
                typ = 8'h20;
                seq = $urandom % 4096;
            end
            dm     = (seq - ma) & 12'hFFF;
            err_e  = dv && (typ == 8'h00) && (dm > out);
            prog_e = dv && (typ == 8'h00) && !err_e && (dm != 0);
            bus.tlp_sent_i   = tlp;
            bus.dllp_valid_i = dv;
            bus.dllp_i       = {typ, 12'h000, 12'(seq)};
            tick();
            if (tlp && ready_e) mn = (mn + 1) & 12'hFFF;
            if (prog_e) ma = seq;
            chk("rnd_next_seq", bus.next_seq_o, mn);
            chk("rnd_purge_seq", bus.purge_seq_o, ma);
            chk("rnd_purge_valid", bus.purge_valid_o, prog_e);
            chk("rnd_err", bus.dllp_err_o, err_e);
            chk("rnd_ready", bus.new_tlp_ready_o, ((mn - ma - 1) & 12'hFFF) != 16);
            chk("rnd_no_replay", bus.replay_valid_o, 0);
        end
        bus.tlp_sent_i   = 1'b0;
        bus.dllp_valid_i = 1'b0;
        bus.dllp_i       = '0;
        chk("rnd_reached_4094", (guard < 30000), 1);

        // ---------------- sequence wrap
        send_tlps(4);
        chk("t8_next_seq_wrap", bus.next_seq_o, 2);
        send_dllp(8'h00, 12'd0);
        chk("t8_purge_valid", bus.purge_valid_o, 1);
        chk("t8_purge_seq", bus.purge_seq_o, 0);
        chk("t8_outstanding", 32'((bus.next_seq_o - bus.purge_seq_o - 12'd1) & 12'hFFF), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
